// File: rtl/dsp_stim_pkg.sv
// Shared definitions for the stimulus playback engine: state encoding,
// default geometry and the I/Q field positions inside a sample word.
package dsp_stim_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;

  // I occupies the low half of a sample, Q the high half.
  localparam int I_LSB = 0;
  localparam int I_MSB = 15;
  localparam int Q_LSB = 16;
  localparam int Q_MSB = 31;

  localparam int LOOP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } stim_state_e;

endpackage

// File: rtl/dsp_stim_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// A same-address write and read in one cycle return the previous contents.
module dsp_stim_mem
  import dsp_stim_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dsp_stim_gen.sv
// Stimulus playback engine: host loads the sample RAM, arms, and on trigger
// the block plays back a programmed number of I/Q samples once or looped.
module dsp_stim_gen
  import dsp_stim_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic [AW:0]           length,
  input  logic                  loop_en,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  stop,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state,
  output logic [LOOP_CNT_W-1:0] loop_cnt
);

  // Handshake: dout_valid qualifies dout for exactly one cycle per sample.
  // There is no ready; the consumer must accept one sample every clock.

  stim_state_e           state_q, state_d;
  logic [AW:0]           addr_q;
  logic [AW:0]           len_q;
  logic [AW:0]           len_m1;
  logic                  loop_q;
  logic [LOOP_CNT_W-1:0] loop_cnt_q;
  logic                  valid_q;
  logic                  done_q;
  logic [DW-1:0]         rdata;

  logic arm_ok;
  logic play_go;
  logic last;
  logic wrap;
  logic finish;
  logic issue;

  assign len_m1 = len_q - (AW+1)'(1);
  assign last   = (addr_q == len_m1);
  assign issue  = (state_q == ST_PLAY) && !stop;

  always_comb begin
    state_d = state_q;
    arm_ok  = 1'b0;
    play_go = 1'b0;
    wrap    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm && (length != '0)) begin
          state_d = ST_ARMED;
          arm_ok  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (trig) begin
          state_d = ST_PLAY;
          play_go = 1'b1;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (last) begin
          if (loop_q) begin
            wrap = 1'b1;
          end else begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The address is AW+1 bits so a full-depth length compares cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
    end else if (play_go || wrap) begin
      addr_q <= '0;
    end else if (state_q == ST_PLAY) begin
      addr_q <= addr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q  <= '0;
      loop_q <= 1'b0;
    end else if (arm_ok) begin
      len_q  <= length;
      loop_q <= loop_en;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loop_cnt_q <= '0;
    end else if (arm_ok) begin
      loop_cnt_q <= '0;
    end else if (wrap && (loop_cnt_q != {LOOP_CNT_W{1'b1}})) begin
      loop_cnt_q <= loop_cnt_q + LOOP_CNT_W'(1);
    end
  end

  // A stop in the issuing cycle squashes the sample that RAM is fetching.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= issue;
      done_q  <= finish;
    end
  end

  dsp_stim_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (state_q == ST_PLAY),
    .raddr (addr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign dout       = valid_q ? rdata : '0;
  assign dout_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE) || valid_q;
  assign state      = state_q;
  assign loop_cnt   = loop_cnt_q;

endmodule

// File: tb/tb_dsp_stim_gen.sv
// Scoreboarded bench for dsp_stim_gen: directed playback scenarios push
// expected {done, dout} words, a negedge monitor pops and compares them.
module tb_dsp_stim_gen;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   length;
  logic          loop_en;
  logic          arm;
  logic          trig;
  logic          stop;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;
  logic [1:0]    state;
  logic [15:0]   loop_cnt;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model [0:DEPTH-1];
  int            n_cmp;
  int            n_err;

  dsp_stim_gen #(
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .length     (length),
    .loop_en    (loop_en),
    .arm        (arm),
    .trig       (trig),
    .stop       (stop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .state      (state),
    .loop_cnt   (loop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    model[addr] = data;
  endtask

  task automatic arm_cfg(input int len, input logic lp);
    length  = (AW+1)'(len);
    loop_en = lp;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push_pass(input int len, input int n, input logic done_last);
    for (int k = 0; k < n; k++)
      exp_q.push_back({done_last && (k == n-1), model[k % len]});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", {31'd0, done, dout}, 64'h1_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        chk("sample", {31'd0, done, dout}, {31'd0, e});
      end
    end else begin
      chk("idle_out", {31'd0, done, dout}, 64'd0);
    end
  end

  initial begin
    logic [DW-1:0] old5;
    logic [DW-1:0] new5;
    logic [15:0]   v;
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    length = '0; loop_en = 1'b0; arm = 1'b0; trig = 1'b0; stop = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loop_cnt", loop_cnt, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      v = 16'(i);
      write_mem(i, {v, ~v});
    end

    // single pass of 8, then re-arm on the tail sample
    arm_cfg(8, 1'b0);
    chk("armed_state", state, 1);
    push_pass(8, 8, 1'b1);
    pulse_trig();
    chk("play_state", state, 2);
    chk("busy_play", busy, 1);
    repeat (8) tick();
    chk("idle_at_last", state, 0);
    chk("last_valid", dout_valid, 1);
    chk("done_last", done, 1);
    chk("busy_tail", busy, 1);
    arm_cfg(3, 1'b0);
    chk("rearm_on_tail", state, 1);
    chk("valid_after_tail", dout_valid, 0);
    pulse_stop();
    chk("stop_armed", state, 0);

    // looped length 3, stopped after 10 samples
    arm_cfg(3, 1'b1);
    push_pass(3, 10, 1'b0);
    pulse_trig();
    repeat (3) tick();
    chk("loop_cnt_first_wrap", loop_cnt, 1);
    repeat (7) tick();
    chk("still_play", state, 2);
    pulse_stop();
    chk("stop_play_state", state, 0);
    chk("stop_play_valid", dout_valid, 0);
    chk("loop_cnt_final", loop_cnt, 3);
    chk("stop_busy", busy, 0);

    // ignored arms, stop priority over trig
    arm_cfg(0, 1'b0);
    chk("arm_len0_ignored", state, 0);
    arm_cfg(4, 1'b0);
    chk("arm_len4", state, 1);
    chk("busy_armed", busy, 1);
    pulse_stop();
    chk("arm_stop", state, 0);
    arm_cfg(4, 1'b0);
    arm_cfg(2, 1'b1);
    chk("arm_in_armed", state, 1);
    trig = 1'b1;
    stop = 1'b1;
    tick();
    trig = 1'b0;
    stop = 1'b0;
    chk("trig_stop_same", state, 0);
    repeat (3) tick();
    chk("no_valid_after_stop", dout_valid, 0);
    arm_cfg(4, 1'b0);
    arm_cfg(2, 1'b1);
    push_pass(4, 4, 1'b1);
    pulse_trig();
    repeat (4) tick();
    chk("latched_len_state", state, 0);
    chk("latched_len_loop_cnt", loop_cnt, 0);
    tick();

    // full depth pass
    arm_cfg(DEPTH, 1'b0);
    push_pass(DEPTH, DEPTH, 1'b1);
    pulse_trig();
    repeat (DEPTH) tick();
    chk("full_idle", state, 0);
    chk("full_done", done, 1);
    tick();
    chk("full_valid_low", dout_valid, 0);
    chk("full_busy_low", busy, 0);

    // write collision on address 5 during first pass
    old5 = model[5];
    new5 = 32'hDEAD_BEEF;
    for (int k = 0; k < 16; k++) begin
      if ((k % 8) == 5) exp_q.push_back({1'b0, (k < 8) ? old5 : new5});
      else              exp_q.push_back({1'b0, model[k % 8]});
    end
    arm_cfg(8, 1'b1);
    pulse_trig();
    repeat (5) tick();
    write_mem(5, new5);
    repeat (10) tick();
    pulse_stop();
    chk("coll_state", state, 0);
    chk("coll_loop_cnt", loop_cnt, 2);

    // asynchronous reset mid-play, then replay with preserved memory
    arm_cfg(8, 1'b0);
    push_pass(8, 8, 1'b1);
    pulse_trig();
    repeat (3) tick();
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_state", state, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_state", state, 0);
    arm_cfg(8, 1'b0);
    push_pass(8, 8, 1'b1);
    pulse_trig();
    repeat (8) tick();
    chk("replay_done", done, 1);
    tick();
    chk("replay_valid_low", dout_valid, 0);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
